// File: rtl/rr_mux_n.sv
// rr_mux_n -- N-channel arbitrated multiplexer with a one-entry registered output.
//
// Several requesters share one downstream port. A grant is chosen internally,
// either round-robin (RR_MODE=1) or fixed priority with the lowest index
// winning (RR_MODE=0). The granted word is captured into an output register
// that drains through a valid/ready handshake. Back-to-back transfers run at
// one word per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   per-channel request, bit i = channel i
//   in_data    channel i word at [i*WIDTH +: WIDTH]
//   in_ready   one-hot or zero; channel i transfers on in_valid[i] & in_ready[i]
//   out_valid  output register holds a word
//   out_ready  downstream accepts the word
//   out_data   registered selected word
//   out_sel    index of the channel that supplied out_data
module rr_mux_n #(
   parameter int WIDTH   = 32,
   parameter int N       = 4,
   parameter int RR_MODE = 1,
   localparam int SELW   = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         in_valid,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic [N-1:0]         in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel
);

   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic [SELW-1:0]   out_sel_q,   out_sel_d;
   logic [SELW-1:0]   ptr_q,       ptr_d;

   logic              load_en;
   logic              gnt_vld;
   logic [SELW-1:0]   gnt_idx;
   logic [SELW-1:0]   ptr_nxt;
   logic [SELW-1:0]   jj;
   int                j;

   // The register can take a word when empty or when it drains this cycle.
   assign load_en = !rst && (!out_valid_q || out_ready);

   // Search from the start index upward (mod N). Scanning k from high to low
   // lets the first hit in search order be the last assignment, so no early exit.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      j       = 0;
      jj      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (RR_MODE != 0) ? int'(ptr_q) + k : k;
         if (j >= N) j = j - N;
         jj = SELW'(j);
         if (in_valid[jj]) begin
            gnt_vld = 1'b1;
            gnt_idx = jj;
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (load_en && gnt_vld) in_ready[gnt_idx] = 1'b1;
   end

   // Next round-robin start: one past the winner, wrapping N-1 -> 0.
   assign ptr_nxt = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (load_en && gnt_vld) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[int'(gnt_idx) * WIDTH +: WIDTH];
         out_sel_d   = gnt_idx;
         if (RR_MODE != 0) ptr_d = ptr_nxt;
      end else if (out_ready) begin
         // Drain with nothing to replace it; data and index hold.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: one round-robin instance (index 0) and one fixed-priority
// instance (index 1). A driver runs a behavioural arbiter model, checks
// in_ready/out_valid and pushes expected words; a separate monitor pops and
// compares whenever a DUT word is accepted downstream.
module tb_rr_mux_n;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int SW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]              rst;
   logic [1:0][N-1:0]       iv, ir;
   logic [1:0][N*W-1:0]     id;
   logic [1:0]              ov, ordy;
   logic [1:0][W-1:0]       od;
   logic [1:0][SW-1:0]      os;

   rr_mux_n #(.WIDTH(W), .N(N), .RR_MODE(1)) u_rr (
      .clk(clk), .rst(rst[0]), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_sel(os[0]));

   rr_mux_n #(.WIDTH(W), .N(N), .RR_MODE(0)) u_fx (
      .clk(clk), .rst(rst[1]), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_sel(os[1]));

   typedef struct {
      logic [W-1:0] d;
      int           s;
   } exp_t;

   exp_t         sbq[2][$];
   int           checks = 0;
   int           errors = 0;
   bit           req_v[2][N];
   logic [W-1:0] req_d[2][N];
   bit           m_ov[2];
   int           m_ptr[2];
   int           last_g;
   logic [N-1:0] last_ir;
   int           p_new;
   bit           rand_rdy;
   logic [W-1:0] d1;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Behavioural arbiter: first valid channel scanning from the start index mod N.
   function automatic int find_g(int m, logic [N-1:0] v, int ptr);
      int base;
      base = (m == 0) ? ptr : 0;
      for (int k = 0; k < N; k++)
         if (v[(base + k) % N]) return (base + k) % N;
      return -1;
   endfunction

   task automatic drive(int m);
      for (int i = 0; i < N; i++) begin
         iv[m][i]          = req_v[m][i];
         id[m][i*W +: W]   = req_d[m][i];
      end
   endtask

   task automatic set_req(int m, int ch, logic [W-1:0] d);
      req_v[m][ch] = 1'b1;
      req_d[m][ch] = d;
   endtask

   task automatic clear_req(int m);
      for (int i = 0; i < N; i++) req_v[m][i] = 1'b0;
      drive(m);
   endtask

   // One clock of instance m: check at negedge, update model, then after the
   // edge retire the granted request and optionally add new random ones.
   task automatic step(int m);
      bit           le, rst_seen;
      int           g;
      logic [N-1:0] er;
      exp_t         e;
      @(negedge clk);
      le = !rst[m] && (!m_ov[m] || ordy[m]);
      g  = find_g(m, iv[m], m_ptr[m]);
      er = '0;
      if (le && g >= 0) er[g] = 1'b1;
      last_ir = ir[m];
      chk("in_ready", ir[m], er);
      chk("out_valid", ov[m], m_ov[m]);
      last_g   = -1;
      rst_seen = rst[m];
      if (rst[m]) begin
         m_ov[m]  = 1'b0;
         m_ptr[m] = 0;
      end else if (le && g >= 0) begin
         e.d = req_d[m][g];
         e.s = g;
         sbq[m].push_back(e);
         m_ov[m] = 1'b1;
         if (m == 0) m_ptr[m] = (g + 1) % N;
         last_g = g;
      end else if (ordy[m]) begin
         m_ov[m] = 1'b0;
      end
      @(posedge clk);
      #1;
      if (rst_seen) sbq[m].delete();
      if (last_g >= 0) req_v[m][last_g] = 1'b0;
      for (int i = 0; i < N; i++)
         if (!req_v[m][i] && $urandom_range(99) < p_new) set_req(m, i, $urandom);
      if (rand_rdy) ordy[m] = ($urandom_range(3) != 0);
      drive(m);
   endtask

   task automatic do_reset(int m);
      rst[m] = 1'b1;
      repeat (2) step(m);
      rst[m] = 1'b0;
   endtask

   // Monitor: every accepted output word must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      for (int m = 0; m < 2; m++) begin
         if (ov[m] && ordy[m]) begin
            if (sbq[m].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word inst %0d: got data %0h sel %0d expected none", m, od[m], os[m]);
            end else begin
               e = sbq[m].pop_front();
               chk("out_data", od[m], e.d);
               chk("out_sel", os[m], e.s);
            end
         end
      end
   end

   initial begin
      rst      = 2'b11;
      iv       = '0;
      id       = '0;
      ordy     = 2'b11;
      p_new    = 0;
      rand_rdy = 1'b0;
      for (int m = 0; m < 2; m++) begin
         m_ov[m] = 1'b0;
         m_ptr[m] = 0;
         for (int i = 0; i < N; i++) begin
            req_v[m][i] = 1'b0;
            req_d[m][i] = '0;
         end
      end

      // Reset with every channel requesting: no in_ready, clean outputs after.
      for (int i = 0; i < N; i++) set_req(0, i, $urandom);
      drive(0);
      step(0);
      step(0);
      rst[0] = 1'b0;
      chk("reset_out_valid", ov[0], 0);
      chk("reset_out_sel", os[0], 0);
      chk("reset_out_data", od[0], 0);
      clear_req(0);

      // Single channel.
      set_req(0, 2, 32'hDEADBEEF);
      drive(0);
      step(0);
      chk("single_ready", last_ir, 4'b0100);
      chk("single_valid", ov[0], 1);
      chk("single_data", od[0], 32'hDEADBEEF);
      chk("single_sel", os[0], 2);
      step(0);

      // Round-robin fairness from ptr=0.
      do_reset(0);
      p_new = 100;
      for (int i = 0; i < N; i++) set_req(0, i, $urandom);
      drive(0);
      for (int k = 0; k < 8; k++) begin
         step(0);
         chk("rr_seq", os[0], k % N);
         chk("rr_valid", ov[0], 1);
      end
      p_new = 0;
      clear_req(0);
      step(0);

      // Backpressure.
      do_reset(0);
      d1 = $urandom;
      set_req(0, 1, d1);
      drive(0);
      step(0);
      set_req(0, 3, $urandom);
      ordy[0] = 1'b0;
      drive(0);
      repeat (3) begin
         step(0);
         chk("bp_sel", os[0], 1);
         chk("bp_data", od[0], d1);
         chk("bp_ready", last_ir, 0);
      end
      ordy[0] = 1'b1;
      step(0);
      chk("bp_release_sel", os[0], 3);
      step(0);

      // Reset mid-operation with a stalled word; pointer restarts at 0.
      set_req(0, 2, $urandom);
      drive(0);
      step(0);
      ordy[0] = 1'b0;
      rst[0]  = 1'b1;
      step(0);
      chk("midrst_valid", ov[0], 0);
      rst[0]  = 1'b0;
      ordy[0] = 1'b1;
      for (int i = 0; i < N; i++) if (!req_v[0][i]) set_req(0, i, $urandom);
      drive(0);
      step(0);
      chk("midrst_first_grant", os[0], 0);
      clear_req(0);
      step(0);

      // Fixed priority: channels 1 and 3 always valid, 1 always wins.
      do_reset(1);
      for (int k = 0; k < 6; k++) begin
         if (!req_v[1][1]) set_req(1, 1, $urandom);
         if (!req_v[1][3]) set_req(1, 3, $urandom);
         drive(1);
         step(1);
         chk("fixed_no3", last_ir[3], 0);
         chk("fixed_sel", os[1], 1);
      end
      clear_req(1);
      step(1);

      // Random traffic, random backpressure, occasional reset.
      for (int m = 0; m < 2; m++) begin
         do_reset(m);
         p_new    = 40;
         rand_rdy = 1'b1;
         repeat (400) begin
            rst[m] = ($urandom_range(99) == 0);
            step(m);
         end
         rst[m]   = 1'b0;
         p_new    = 0;
         rand_rdy = 1'b0;
         ordy[m]  = 1'b1;
         clear_req(m);
         repeat (3) step(m);
         chk("sb_empty", sbq[m].size(), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
